l2_arbiter_rr: RTL
==================

# l2_arbiter_rr

Parametrised round-robin arbiter between NUM_REQ L1 cache miss ports (I-cache, D-cache, prefetcher, ...) and the single shared L2 cache port. Replaces the fixed two-requester I/D arbiter. Adds:
- N requesters with fair rotating priority;
- registered address and write data captured at grant;
- back-to-back grants with no idle bubble;
- response routing to the granted requester only.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (≥2); index 0 is the I-cache by convention.
- ADDR_WIDTH, 32, line address width.
- DATA_WIDTH, 256, cache-line width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_read  in  NUM_REQ  per-requester read request; held until matching req_resp.
- req_write  in  NUM_REQ  per-requester write request; held until matching req_resp.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write lines.
- req_resp  out  NUM_REQ  one-hot completion pulse to the granted requester.
- req_rdata  out  DATA_WIDTH  read line, broadcast; valid only with req_resp.
- l2_read  out  1  read request to L2.
- l2_write  out  1  write request to L2.
- l2_addr  out  ADDR_WIDTH  registered address.
- l2_wdata  out  DATA_WIDTH  registered write line.
- l2_resp  in  1  L2 completion, single-cycle pulse.
- l2_rdata  in  DATA_WIDTH  L2 read line.
- grant_id  out  max(1,$clog2(NUM_REQ))  index of current owner; valid while busy.
- busy  out  1  a transaction is outstanding at L2.

## Operation
- States: IDLE, BUSY. Registers: state, grant_id, op_write, l2_addr, l2_wdata, rr_ptr.
- Pending vector: pend[i] = req_read[i] | req_write[i].
- Winner selection (IDLE): first set bit of pend scanning from rr_ptr upward, wrapping mod NUM_REQ.
- Grant capture: on a winner at a clock edge, latch grant_id, req_addr slice, req_wdata slice and op_write = req_write[winner] (write wins if both read and write are set). Go to BUSY.
- BUSY outputs:
  - l2_read = ~op_write; l2_write = op_write; busy = 1.
  - Requester inputs are ignored; deasserting the owner's request early does not abort the transaction.
- Completion: l2_resp in BUSY drives req_resp[grant_id] = 1 and req_rdata = l2_rdata combinationally in the same cycle. rr_ptr ← (grant_id+1) mod NUM_REQ.
- Back-to-back: in the l2_resp cycle, re-arbitrate over pend with bit grant_id masked (the owner still holds its request that cycle). Scan starts at (grant_id+1) mod NUM_REQ.
  - If a winner exists: capture it and stay in BUSY.
  - Otherwise: go to IDLE.
- l2_resp outside BUSY is ignored; req_resp stays 0.
- Fairness: a continuously pending requester is granted within NUM_REQ−1 other grants.

## Timing
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, grant_id=0, op_write=0, l2_addr=0, l2_wdata=0.
  - l2_read=0, l2_write=0, busy=0, req_resp=0 immediately, not waiting for a clock.
  - Reset mid-transaction drops l2_read/l2_write at once. The in-flight response is discarded.
- Grant latency: request visible before edge k in IDLE → l2_read/l2_write, l2_addr, busy valid from cycle k+1.
- Completion latency: l2_resp in cycle m → req_resp same cycle m.
  - Next L2 request, if any, is driven from cycle m+1 with the new address. l2_read/l2_write stay high across the boundary; the owner change is visible on grant_id.
  - With no pending request, l2_read/l2_write/busy are 0 in cycle m+1.
- req_resp is never high for more than one cycle per transaction and is at most one-hot.

## Test plan
- Reset: assert rst_n=0 mid-BUSY → l2_read, l2_write, busy drop in the same cycle. After release with no requests, all outputs stay 0.
- Single read, NUM_REQ=2: req_read[0]=1, addr 0x1000 at edge 1.
  - l2_read=1 and l2_addr=0x1000 from cycle 2.
  - l2_resp in cycle 5 with rdata 0xA5.. → req_resp=2'b01 and req_rdata=0xA5.. in cycle 5; l2_read=0 in cycle 6.
- Back-to-back: req_read[0] and req_write[1] both high in IDLE (rr_ptr=0).
  - Requester 0 is granted first.
  - On its l2_resp, l2_write=1 with requester 1's address and wdata from the next cycle, with no IDLE cycle between.
- Round-robin, NUM_REQ=4: all four requesters read continuously → grant order 0,1,2,3,0. Each req_resp is one-hot to the matching index.
- Read+write from one requester: req_read[2]=req_write[2]=1 → L2 sees l2_write=1, l2_read=0.
- Early drop and stray response: owner deasserts its request mid-BUSY → transaction still completes with req_resp on l2_resp. An l2_resp pulse in IDLE → req_resp stays 0.

Source files
------------

// File: rtl/l2_arbiter_rr.sv
// Round-robin arbiter from NUM_REQ L1 miss ports onto one L2 port; addr/wdata registered at grant.
// Grant visible the cycle after the request; completion routed in the l2_resp cycle with back-to-back re-grant; requests hold until their req_resp.
module l2_arbiter_rr #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [NUM_REQ-1:0]                              req_read,
    input  logic [NUM_REQ-1:0]                              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]                   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]                   req_wdata,
    output logic [NUM_REQ-1:0]                              req_resp,
    output logic [DATA_WIDTH-1:0]                           req_rdata,
    output logic                                            l2_read,
    output logic                                            l2_write,
    output logic [ADDR_WIDTH-1:0]                           l2_addr,
    output logic [DATA_WIDTH-1:0]                           l2_wdata,
    input  logic                                            l2_resp,
    input  logic [DATA_WIDTH-1:0]                           l2_rdata,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                                            busy
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state, state_nxt;
    logic [NUM_REQ-1:0]    pend, cand;
    logic [GID_W-1:0]      rr_ptr, scan_base, win_id, after_owner, idx;
    logic                  win_vld, done, take, op_write;
    int                    pos;
    logic [ADDR_WIDTH-1:0] addr_slice  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_slice [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign addr_slice[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_slice[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign pend        = req_read | req_write;
    assign done        = (state == BUSY) && l2_resp;
    assign take        = win_vld && ((state == IDLE) || done);
    assign after_owner = (grant_id == GID_W'(NUM_REQ - 1)) ? '0 : grant_id + GID_W'(1);
    assign req_rdata   = l2_rdata;

    // In BUSY the owner still holds its request, so it is masked and the scan starts just past it.
    always_comb begin
        cand      = pend;
        scan_base = rr_ptr;
        win_vld   = 1'b0;
        win_id    = '0;
        idx       = '0;
        pos       = 0;
        if (state == BUSY) begin
            cand[grant_id] = 1'b0;
            scan_base      = after_owner;
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = int'(scan_base) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = GID_W'(pos);
            if (cand[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        l2_read   = 1'b0;
        l2_write  = 1'b0;
        req_resp  = '0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                busy     = 1'b1;
                l2_read  = ~op_write;
                l2_write = op_write;
                if (l2_resp) begin
                    req_resp[grant_id] = 1'b1;
                    if (!win_vld) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write wins when a requester raises both read and write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id <= '0;
            op_write <= 1'b0;
            l2_addr  <= '0;
            l2_wdata <= '0;
            rr_ptr   <= '0;
        end else begin
            if (take) begin
                grant_id <= win_id;
                op_write <= req_write[win_id];
                l2_addr  <= addr_slice[win_id];
                l2_wdata <= wdata_slice[win_id];
            end
            if (done) begin
                rr_ptr <= after_owner;
            end
        end
    end
endmodule
